// File: rtl/pwm_fault_pkg.sv
// pwm_fault_pkg: shared state encoding and constants for the PWM fault filter.
package pwm_fault_pkg;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUAL    = 3'd1,
    ST_ACTIVE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_LATCHED = 3'd4
  } fault_state_e;
  localparam int unsigned MIN_FILT_LEN = 1;
endpackage

// File: rtl/fault_sync.sv
// fault_sync: multi-stage synchronizer for an asynchronous pad with a configurable reset level.
module fault_sync #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;
  always_ff @(posedge clk) chain <= rst ? {STAGES{RST_VAL}} : {chain[STAGES-2:0], d};
  assign q = chain[STAGES-1];
endmodule

// File: rtl/pwm_fault_filter.sv
// pwm_fault_filter: synchronizes, deglitches and optionally latches a PWM fault pad,
// with saturating counters for qualified faults and rejected glitches.
module pwm_fault_filter
  import pwm_fault_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit POLARITY = 1'b1,
  parameter int FILT_W = 8,
  parameter int CNT_W = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              fault_raw_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic              latch_en_i,
  input  logic              clear_i,
  input  logic              cnt_clr_i,
  output logic              fault_o,
  output logic              fault_evt_o,
  output logic [2:0]        state_o,
  output logic [CNT_W-1:0]  fault_cnt_o,
  output logic [CNT_W-1:0]  glitch_cnt_o
);
  localparam logic [FILT_W-1:0] MIN_LEN = FILT_W'(MIN_FILT_LEN);
  fault_state_e state;
  logic [FILT_W-1:0] cnt, len;
  logic [FILT_W:0] cnt_nxt;
  logic sync_q, a, len_one, reached, new_fault, glitch;
  fault_sync #(.STAGES(SYNC_STAGES), .RST_VAL(~POLARITY)) u_sync (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .d(fault_raw_i),
    .q(sync_q)
  );
  assign a = sync_q ^ ~POLARITY;
  assign len = (filt_len_i < MIN_LEN) ? MIN_LEN : filt_len_i;
  assign len_one = len == MIN_LEN;
  // one bit wider so the +1 compare cannot wrap at the top of the range
  assign cnt_nxt = {1'b0, cnt} + {{FILT_W{1'b0}}, 1'b1};
  assign reached = cnt_nxt >= {1'b0, len};
  assign new_fault = a && ((state == ST_IDLE && len_one) || (state == ST_QUAL && reached));
  assign glitch = state == ST_QUAL && !a;
  assign state_o = state;
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic inc, input logic clr);
    logic [CNT_W-1:0] base;
    base = clr ? '0 : v;
    return (inc && ~&base) ? base + CNT_W'(1) : base;
  endfunction
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      fault_o     <= 1'b0;
      fault_evt_o <= 1'b0;
    end else begin
      fault_evt_o <= new_fault;
      case (state)
        ST_IDLE: if (a) begin
          cnt <= FILT_W'(1);
          state <= len_one ? ST_ACTIVE : ST_QUAL;
          fault_o <= len_one;
        end
        ST_QUAL:
          if (!a) state <= ST_IDLE;
          else if (reached) begin
            state <= ST_ACTIVE;
            fault_o <= 1'b1;
          end else cnt <= cnt_nxt[FILT_W-1:0];
        ST_ACTIVE: if (!a) begin
          cnt <= FILT_W'(1);
          if (latch_en_i) state <= ST_LATCHED;
          else if (len_one) begin
            state <= ST_IDLE;
            fault_o <= 1'b0;
          end else state <= ST_RELEASE;
        end
        ST_RELEASE:
          if (a) begin
            state <= ST_ACTIVE;
            cnt <= '0;
          end else if (reached) begin
            state <= ST_IDLE;
            fault_o <= 1'b0;
          end else cnt <= cnt_nxt[FILT_W-1:0];
        ST_LATCHED: if (clear_i && !a) begin
          state <= ST_IDLE;
          fault_o <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          fault_o <= 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge wb_clk_i) begin
    fault_cnt_o  <= wb_rst_i ? '0 : bump(fault_cnt_o, new_fault, cnt_clr_i);
    glitch_cnt_o <= wb_rst_i ? '0 : bump(glitch_cnt_o, glitch, cnt_clr_i);
  end
endmodule

// File: tb/tb_pwm_fault_filter.sv
// tb_pwm_fault_filter: directed self-checking bench for pwm_fault_filter.
module tb_pwm_fault_filter;
  logic wb_clk_i = 1'b0, wb_rst_i = 1'b1;
  logic raw = 1'b0, latch_en = 1'b0, clear = 1'b0, cnt_clr = 1'b0;
  logic [7:0] filt_len = 8'd4;
  logic fault_o, fault_evt_o;
  logic [2:0] state_o;
  logic [7:0] fault_cnt_o, glitch_cnt_o;
  logic raw_n = 1'b1;
  logic [7:0] filt_len_n = 8'd1;
  logic fault_n, evt_n;
  logic [2:0] state_n;
  logic [7:0] fcnt_n, gcnt_n;
  int tests = 0, fails = 0, evt_seen = 0;
  always #5 wb_clk_i = ~wb_clk_i;
  pwm_fault_filter dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .fault_raw_i(raw), .filt_len_i(filt_len),
    .latch_en_i(latch_en), .clear_i(clear), .cnt_clr_i(cnt_clr), .fault_o(fault_o),
    .fault_evt_o(fault_evt_o), .state_o(state_o), .fault_cnt_o(fault_cnt_o), .glitch_cnt_o(glitch_cnt_o)
  );
  pwm_fault_filter #(.POLARITY(1'b0)) dut_n (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .fault_raw_i(raw_n), .filt_len_i(filt_len_n),
    .latch_en_i(1'b0), .clear_i(1'b0), .cnt_clr_i(1'b0), .fault_o(fault_n),
    .fault_evt_o(evt_n), .state_o(state_n), .fault_cnt_o(fcnt_n), .glitch_cnt_o(gcnt_n)
  );
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge wb_clk_i);
      evt_seen += int'(fault_evt_o);
    end
  endtask
  task automatic test_reset;
    step(2);
    tests++; if ({fault_o, fault_evt_o, state_o, fault_cnt_o, glitch_cnt_o} !== '0) begin fails++; $display("FAIL reset_outputs got %b want all 0", {fault_o, fault_evt_o, state_o, fault_cnt_o, glitch_cnt_o}); end
    wb_rst_i = 1'b0;
    step(6);
    tests++; if (state_o !== 3'd0 || glitch_cnt_o !== 8'd0) begin fails++; $display("FAIL post_reset_idle state %0d glitch %0d want 0 0", state_o, glitch_cnt_o); end
    tests++; if (fault_n !== 1'b0 || state_n !== 3'd0) begin fails++; $display("FAIL pol0_no_fault fault %0b state %0d want 0 0", fault_n, state_n); end
  endtask
  task automatic test_glitch;
    bit seen_fault = 0, seen_qual = 0;
    filt_len = 8'd4; evt_seen = 0;
    raw = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) raw = 1'b0;
      step(1);
      seen_fault |= fault_o;
      seen_qual |= (state_o == 3'd1);
    end
    tests++; if (seen_fault || evt_seen != 0) begin fails++; $display("FAIL glitch_fault fault %0b evts %0d want 0 0", seen_fault, evt_seen); end
    tests++; if (!seen_qual) begin fails++; $display("FAIL glitch_qual seen %0b want 1", seen_qual); end
    tests++; if (glitch_cnt_o !== 8'd1 || state_o !== 3'd0) begin fails++; $display("FAIL glitch_cnt got %0d state %0d want 1 0", glitch_cnt_o, state_o); end
  endtask
  task automatic test_filter;
    filt_len = 8'd4; latch_en = 1'b0; evt_seen = 0;
    raw = 1'b1;
    step(5);
    tests++; if (fault_o !== 1'b0) begin fails++; $display("FAIL rise_early got %0b want 0", fault_o); end
    step(1);
    tests++; if (fault_o !== 1'b1 || state_o !== 3'd2) begin fails++; $display("FAIL rise_on_time fault %0b state %0d want 1 2", fault_o, state_o); end
    step(4);
    raw = 1'b0;
    step(5);
    tests++; if (fault_o !== 1'b1 || state_o !== 3'd3) begin fails++; $display("FAIL fall_early fault %0b state %0d want 1 3", fault_o, state_o); end
    step(1);
    tests++; if (fault_o !== 1'b0 || state_o !== 3'd0) begin fails++; $display("FAIL fall_on_time fault %0b state %0d want 0 0", fault_o, state_o); end
    tests++; if (fault_cnt_o !== 8'd1 || evt_seen != 1) begin fails++; $display("FAIL filter_events cnt %0d evts %0d want 1 1", fault_cnt_o, evt_seen); end
  endtask
  task automatic test_latch;
    filt_len = 8'd3; latch_en = 1'b1; evt_seen = 0;
    raw = 1'b1;
    step(8);
    tests++; if (fault_o !== 1'b1 || state_o !== 3'd2) begin fails++; $display("FAIL latch_active fault %0b state %0d want 1 2", fault_o, state_o); end
    raw = 1'b0;
    step(4);
    tests++; if (fault_o !== 1'b1 || state_o !== 3'd4) begin fails++; $display("FAIL latched fault %0b state %0d want 1 4", fault_o, state_o); end
    raw = 1'b1;
    step(3);
    clear = 1'b1; step(1); clear = 1'b0; step(1);
    tests++; if (fault_o !== 1'b1 || state_o !== 3'd4) begin fails++; $display("FAIL clear_ignored fault %0b state %0d want 1 4", fault_o, state_o); end
    raw = 1'b0; latch_en = 1'b0;
    step(4);
    tests++; if (state_o !== 3'd4) begin fails++; $display("FAIL latch_en_drop state %0d want 4", state_o); end
    clear = 1'b1; step(1); clear = 1'b0;
    tests++; if (fault_o !== 1'b0 || state_o !== 3'd0) begin fails++; $display("FAIL clear_release fault %0b state %0d want 0 0", fault_o, state_o); end
    tests++; if (fault_cnt_o !== 8'd2 || evt_seen != 1) begin fails++; $display("FAIL latch_events cnt %0d evts %0d want 2 1", fault_cnt_o, evt_seen); end
  endtask
  task automatic test_reentry;
    bit low_seen = 0, rel_seen = 0;
    filt_len = 8'd5; evt_seen = 0;
    raw = 1'b1;
    step(9);
    tests++; if (fault_o !== 1'b1) begin fails++; $display("FAIL reentry_rise got %0b want 1", fault_o); end
    raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) raw = 1'b1;
      step(1);
      low_seen |= ~fault_o;
      rel_seen |= (state_o == 3'd3);
    end
    tests++; if (low_seen || !rel_seen || state_o !== 3'd2) begin fails++; $display("FAIL reentry_hold low %0b release %0b state %0d want 0 1 2", low_seen, rel_seen, state_o); end
    tests++; if (fault_cnt_o !== 8'd3 || evt_seen != 1) begin fails++; $display("FAIL reentry_events cnt %0d evts %0d want 3 1", fault_cnt_o, evt_seen); end
    raw = 1'b0;
    step(8);
    tests++; if (fault_o !== 1'b0 || state_o !== 3'd0) begin fails++; $display("FAIL reentry_fall fault %0b state %0d want 0 0", fault_o, state_o); end
  endtask
  task automatic test_saturation;
    filt_len = 8'd0;
    cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;
    tests++; if (fault_cnt_o !== 8'd0 || glitch_cnt_o !== 8'd0) begin fails++; $display("FAIL cnt_clr got %0d %0d want 0 0", fault_cnt_o, glitch_cnt_o); end
    evt_seen = 0;
    for (int i = 0; i < 260; i++) begin
      raw = 1'b1; step(2); raw = 1'b0; step(2);
    end
    step(4);
    tests++; if (fault_cnt_o !== 8'd255 || evt_seen != 260) begin fails++; $display("FAIL saturate cnt %0d evts %0d want 255 260", fault_cnt_o, evt_seen); end
    raw = 1'b1; step(2);
    cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;
    tests++; if (fault_cnt_o !== 8'd1 || fault_evt_o !== 1'b1) begin fails++; $display("FAIL clr_with_inc cnt %0d evt %0b want 1 1", fault_cnt_o, fault_evt_o); end
    raw = 1'b0; step(4);
  endtask
  task automatic test_reset_mid;
    filt_len = 8'd1; latch_en = 1'b1;
    raw = 1'b1; step(3); raw = 1'b0; step(3);
    tests++; if (state_o !== 3'd4) begin fails++; $display("FAIL pre_reset_latched state %0d want 4", state_o); end
    wb_rst_i = 1'b1; step(1);
    tests++; if ({fault_o, fault_evt_o, state_o, fault_cnt_o, glitch_cnt_o} !== '0) begin fails++; $display("FAIL reset_latched got %b want all 0", {fault_o, fault_evt_o, state_o, fault_cnt_o, glitch_cnt_o}); end
    wb_rst_i = 1'b0; latch_en = 1'b0; filt_len = 8'd4;
    raw = 1'b1; step(3);
    tests++; if (state_o !== 3'd1) begin fails++; $display("FAIL pre_reset_qual state %0d want 1", state_o); end
    wb_rst_i = 1'b1; raw = 1'b0; step(1);
    tests++; if (fault_o !== 1'b0 || state_o !== 3'd0 || glitch_cnt_o !== 8'd0) begin fails++; $display("FAIL reset_qual fault %0b state %0d glitch %0d want 0 0 0", fault_o, state_o, glitch_cnt_o); end
    wb_rst_i = 1'b0; step(6);
    tests++; if (state_o !== 3'd0 || fault_n !== 1'b0) begin fails++; $display("FAIL after_reset state %0d pol0 fault %0b want 0 0", state_o, fault_n); end
    raw_n = 1'b0; step(3);
    tests++; if (fault_n !== 1'b1 || evt_n !== 1'b1) begin fails++; $display("FAIL pol0_active fault %0b evt %0b want 1 1", fault_n, evt_n); end
    raw_n = 1'b1; step(3);
    tests++; if (fault_n !== 1'b0 || fcnt_n !== 8'd1) begin fails++; $display("FAIL pol0_release fault %0b cnt %0d want 0 1", fault_n, fcnt_n); end
  endtask
  initial begin
    test_reset;
    test_glitch;
    test_filter;
    test_latch;
    test_reentry;
    test_saturation;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
